// File: rtl/inverter_pe.sv
// inverter_pe: NoC processing element placed downstream of the scheduler.
// Addressed flits from the router are buffered in a small FIFO. Each buffered
// packet leaves with its payload bitwise inverted, its packet number kept, and
// its address rewritten to the scheduler node (DEST_X, DEST_Y).
//
// Flit layout, MSB to LSB: payload[DW], pck_no[pck_num], y[y_size], x[x_size]
//
// Ports:
//   clk, rst     rising-edge clock; asynchronous active-high reset
//   i_valid      flit from the router is valid
//   i_data       flit from the router
//   o_ready      node can accept a flit (registered, independent of i_ready)
//   o_valid      result flit is valid
//   o_data       result flit
//   i_ready      router accepts the result flit
//   o_pkt_cnt    result flits sent, saturating at 16'hFFFF
//   o_drop_cnt   misaddressed flits dropped, saturating at 8'hFF
//
// Handshake: a transfer happens on a rising edge where valid & ready are both
// high. A valid source holds its data stable until that edge; ready never
// depends combinationally on the matching valid.
module inverter_pe #(
    parameter int X           = 0,
    parameter int Y           = 0,
    parameter int DEST_X      = 0,
    parameter int DEST_Y      = 0,
    parameter int total_width = 24,
    parameter int x_size      = 2,
    parameter int y_size      = 2,
    parameter int pck_num     = 4,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    input  logic [total_width-1:0] i_data,
    output logic                   o_ready,
    output logic                   o_valid,
    output logic [total_width-1:0] o_data,
    input  logic                   i_ready,
    output logic [15:0]            o_pkt_cnt,
    output logic [7:0]             o_drop_cnt
);
    localparam int DW = total_width - x_size - y_size - pck_num;
    localparam int EW = DW + pck_num;
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [x_size-1:0] X_L      = x_size'(X);
    localparam logic [y_size-1:0] Y_L      = y_size'(Y);
    localparam logic [x_size-1:0] DEST_X_L = x_size'(DEST_X);
    localparam logic [y_size-1:0] DEST_Y_L = y_size'(DEST_Y);
    localparam logic [AW:0]       FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]       CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]     PTR_ONE  = AW'(1);

    logic [EW-1:0]          mem_q [FIFO_DEPTH];
    logic [EW-1:0]          mem_d [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic                   ready_q, ready_d;
    logic                   valid_q, valid_d;
    logic [total_width-1:0] data_q, data_d;
    logic [15:0]            pkt_cnt_q, pkt_cnt_d;
    logic [7:0]             drop_cnt_q, drop_cnt_d;

    logic [x_size-1:0] in_x;
    logic [y_size-1:0] in_y;
    logic [EW-1:0]     in_entry;
    logic [EW-1:0]     head;
    logic              accept;
    logic              addr_hit;
    logic              push;
    logic              pop;
    logic              fifo_empty;

    assign in_x       = i_data[x_size-1:0];
    assign in_y       = i_data[x_size +: y_size];
    // Payload and packet number are adjacent, so the entry is one slice.
    assign in_entry   = i_data[total_width-1:x_size+y_size];
    assign head       = mem_q[rd_ptr_q];

    assign accept     = i_valid & ready_q;
    assign addr_hit   = (in_x == X_L) && (in_y == Y_L);
    assign push       = accept & addr_hit;
    assign fifo_empty = (count_q == '0);
    // The output register refills whenever it is empty or being drained.
    assign pop        = !fifo_empty && (!valid_q || i_ready);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        valid_d    = valid_q;
        data_d     = data_q;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (pop) begin
            valid_d = 1'b1;
            data_d  = {~head[EW-1:pck_num], head[pck_num-1:0], DEST_Y_L, DEST_X_L};
        end else if (i_ready) begin
            valid_d = 1'b0;
        end

        if (valid_q && i_ready && (pkt_cnt_q != 16'hFFFF)) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
        end
        if (accept && !addr_hit && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Registered ready: low during reset, and a pop while full only frees a
    // slot on the following cycle.
    assign ready_d = (count_d != FULL_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_data     = data_q;
    assign o_pkt_cnt  = pkt_cnt_q;
    assign o_drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_inverter_pe.sv
module tb_inverter_pe;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic [TW-1:0] i_data = '0;
  logic          i_ready = 1'b0;
  logic          o_ready;
  logic          o_valid;
  logic [TW-1:0] o_data;
  logic [15:0]   o_pkt_cnt;
  logic [7:0]    o_drop_cnt;

  int n_checks = 0;
  int n_fail = 0;
  logic [TW-1:0] exp_q[$];

  typedef struct {
    logic [TW-1:0] din;
    logic          exp_valid;
    logic [TW-1:0] exp_out;
    logic [7:0]    exp_drop;
  } vec_t;
  vec_t vecs[7];

  inverter_pe #(
    .X(1), .Y(2), .DEST_X(0), .DEST_Y(0),
    .total_width(24), .x_size(2), .y_size(2), .pck_num(4), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
    .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
    .o_pkt_cnt(o_pkt_cnt), .o_drop_cnt(o_drop_cnt)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required end of test");
    $fatal(1, "watchdog");
  end

  // helpers
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  function automatic logic [TW-1:0] mk(input logic [15:0] p, input logic [3:0] n);
    return {p, n, 2'd2, 2'd1};
  endfunction

  function automatic logic [TW-1:0] model(input logic [TW-1:0] d);
    return {~d[23:8], d[7:4], 4'h0};
  endfunction

  function automatic logic is_addr(input logic [TW-1:0] d);
    return (d[1:0] == 2'd1) && (d[3:2] == 2'd2);
  endfunction

  // driver: one flit for one cycle; acc reports whether the next edge takes it
  task automatic send(input logic [TW-1:0] d, output logic acc);
    i_valid = 1'b1;
    i_data  = d;
    acc     = o_ready;
    if (acc && is_addr(d)) exp_q.push_back(model(d));
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("drain_outstanding", exp_q.size(), 0);
  endtask

  // scoreboard: in-order results and stability under backpressure
  logic          hold_prev = 1'b0;
  logic [TW-1:0] data_prev = '0;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", o_valid, 1);
        check("hold_data", o_data, data_prev);
      end
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got %h, required no output", o_data);
        end else begin
          check("out_data", o_data, exp_q.pop_front());
        end
      end
      hold_prev = o_valid && !i_ready;
      data_prev = o_data;
    end
  end

  // test sequence
  initial begin
    logic acc;
    int n_acc;
    int seen_at;
    logic [TW-1:0] got;
    logic [15:0] p;

    vecs[0] = '{24'h00FF59, 1'b1, 24'hFF0050, 8'd0};
    vecs[1] = '{24'h12345A, 1'b0, 24'h000000, 8'd1};
    vecs[2] = '{24'h000009, 1'b1, 24'hFFFF00, 8'd1};
    vecs[3] = '{24'hFFFFF9, 1'b1, 24'h0000F0, 8'd1};
    vecs[4] = '{24'hA5C399, 1'b1, 24'h5A3C90, 8'd1};
    vecs[5] = '{24'h123455, 1'b0, 24'h000000, 8'd2};
    vecs[6] = '{24'h123439, 1'b1, 24'hEDCB30, 8'd2};

    // reset state
    repeat (2) tick();
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_pkt_cnt", o_pkt_cnt, 0);
    check("rst_drop_cnt", o_drop_cnt, 0);
    check("rst_o_ready", o_ready, 0);
    rst = 1'b0;
    check("ready_before_edge", o_ready, 0);
    tick();
    check("ready_after_release", o_ready, 1);

    // table: single packets, misaddressed flits, pck_no corners
    i_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      send(vecs[v].din, acc);
      check("vec_accept", acc, 1);
      seen_at = -1;
      got = '0;
      for (int k = 0; k < 3; k++) begin
        if (o_valid && seen_at < 0) begin
          seen_at = k;
          got = o_data;
        end
        tick();
      end
      check("vec_latency", seen_at, vecs[v].exp_valid ? 1 : -1);
      if (vecs[v].exp_valid) check("vec_data", got, vecs[v].exp_out);
      check("vec_drop_cnt", o_drop_cnt, vecs[v].exp_drop);
      check("vec_ready", o_ready, 1);
    end
    check("table_pkt_cnt", o_pkt_cnt, 5);

    // backpressure and fill: FIFO plus output register hold 5
    i_ready = 1'b0;
    n_acc = 0;
    for (int k = 1; k <= 6; k++) begin
      send(mk(16'hC000 + 16'(k), 4'(k)), acc);
      n_acc += int'(acc);
    end
    check("fill_accepted", n_acc, 5);
    check("fill_ready_low", o_ready, 0);
    repeat (3) tick();
    check("full_ready_low", o_ready, 0);
    check("full_valid", o_valid, 1);
    check("full_head", o_data, model(mk(16'hC001, 4'd1)));
    i_ready = 1'b1;
    check("pop_cycle_ready_low", o_ready, 0);
    tick();
    check("ready_after_pop", o_ready, 1);
    wait_drain(20);
    tick();
    check("drained_valid_low", o_valid, 0);
    check("fill_pkt_cnt", o_pkt_cnt, 10);
    check("fill_drop_cnt", o_drop_cnt, 2);

    // streaming with pointer wrap, no bubbles
    for (int k = 0; k < 18; k++) begin
      if (k < 16) begin
        p = 16'(k * 16'h1111) ^ 16'h5A5A;
        i_valid = 1'b1;
        i_data = mk(p, 4'(k));
        check("stream_ready", o_ready, 1);
        exp_q.push_back(model(i_data));
      end else begin
        i_valid = 1'b0;
      end
      if (k >= 2) check("stream_no_bubble", o_valid, 1);
      tick();
    end
    i_valid = 1'b0;
    wait_drain(20);
    tick();
    check("stream_valid_low", o_valid, 0);
    check("stream_pkt_cnt", o_pkt_cnt, 26);

    // reset mid-stream with 3 flits buffered
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(mk(16'h7777, 4'(k)), acc);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_valid", o_valid, 0);
    check("mid_rst_data", o_data, 0);
    check("mid_rst_pkt_cnt", o_pkt_cnt, 0);
    check("mid_rst_drop_cnt", o_drop_cnt, 0);
    check("mid_rst_ready", o_ready, 0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    check("mid_ready_before_edge", o_ready, 0);
    tick();
    check("mid_ready_after_edge", o_ready, 1);
    i_ready = 1'b1;
    send(24'h00FF59, acc);
    check("post_rst_accept", acc, 1);
    wait_drain(10);
    tick();
    check("post_rst_pkt_cnt", o_pkt_cnt, 1);
    check("post_rst_valid_low", o_valid, 0);

    // drop counter saturation
    for (int k = 0; k < 256; k++) send({16'hDEAD, 4'(k), 2'd0, 2'd0}, acc);
    check("sat_drop_cnt", o_drop_cnt, 8'hFF);
    send(24'h12345A, acc);
    tick();
    check("sat_drop_hold", o_drop_cnt, 8'hFF);
    check("sat_no_output", o_valid, 0);
    send(24'hA5C399, acc);
    check("sat_accept", acc, 1);
    wait_drain(10);
    tick();
    check("sat_pkt_cnt", o_pkt_cnt, 2);
    check("sat_drop_final", o_drop_cnt, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
